// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the L1-D refill/writeback port to L2 between hardware threads.
// Optional WAIT watchdog enabled by defining L2_REQ_TIMEOUT_EN.
module l2_req_arbiter #(
  parameter int THREADS = 4,
  parameter int TID_W   = 2,
  parameter int ADDR_W  = 28,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [THREADS-1:0]        i_req_valid,
  input  logic [THREADS-1:0]        i_req_dirty,
  input  logic [THREADS*ADDR_W-1:0] i_req_addr,
  input  logic                      i_flush,
  input  logic [TID_W-1:0]          i_flush_thread,
  input  logic                      i_l2_busy,
  input  logic                      i_l2_rdy,
  output logic                      o_drq,
  output logic [ADDR_W-1:0]         o_l2_addr,
  output logic                      o_access_l2_clean,
  output logic                      o_access_l2_dirty,
  output logic [TID_W-1:0]          o_l2_thread,
  output logic                      o_thread_rdy,
  output logic [TID_W-1:0]          o_rdy_thread,
  output logic [THREADS-1:0]        o_grant_ack,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  // IDLE: arbitrate | REQ: one-cycle drq | WAIT: await l2_rdy | DONE: ack owner, advance ptr
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  if (TID_W != $clog2(THREADS)) begin : g_bad_tid_w
    $error("TID_W must equal clog2(THREADS)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TID_W-1:0]    r_ptr;
  logic [TID_W-1:0]    r_tid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_dirty;
  logic                r_cancel;
  logic [TID_W-1:0]    w_scan;
  logic [TID_W-1:0]    w_sel;
  logic                w_found;
  logic                w_grant;
  logic                w_flush_hit;

`ifdef L2_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_timeout_err;
  logic                w_timeout;
  assign w_timeout     = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  // Scan ptr+1, ptr+2, ... wrapping; the first requester found wins.
  always_comb begin
    w_scan  = r_ptr;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < THREADS; k++) begin
      w_scan = (w_scan == TID_W'(THREADS - 1)) ? '0 : w_scan + 1'b1;
      if (i_req_valid[w_scan] && !w_found) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
    end
  end

  assign w_grant     = w_found && !i_l2_busy;
  assign w_flush_hit = i_flush && (i_flush_thread == r_tid);

  always_comb begin
    w_state_nxt       = r_state;
    o_drq             = 1'b0;
    o_l2_addr         = '0;
    o_access_l2_clean = 1'b0;
    o_access_l2_dirty = 1'b0;
    o_l2_thread       = '0;
    o_thread_rdy      = 1'b0;
    o_rdy_thread      = '0;
    o_grant_ack       = '0;
    o_busy            = (r_state != S_IDLE);
    if (r_state != S_IDLE) begin
      o_l2_addr         = r_addr;
      o_access_l2_clean = !r_dirty;
      o_access_l2_dirty = r_dirty;
      o_l2_thread       = r_tid;
    end
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_REQ;
      S_REQ: begin
        o_drq       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_l2_rdy) w_state_nxt = S_DONE;
`ifdef L2_REQ_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        o_grant_ack[r_tid] = 1'b1;
        o_thread_rdy       = !r_cancel;
        o_rdy_thread       = r_cancel ? '0 : r_tid;
        w_state_nxt        = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= TID_W'(THREADS - 1);
      r_tid    <= '0;
      r_addr   <= '0;
      r_dirty  <= 1'b0;
      r_cancel <= 1'b0;
`ifdef L2_REQ_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_tid    <= w_sel;
          r_addr   <= i_req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
          r_dirty  <= i_req_dirty[w_sel];
          r_cancel <= i_flush && (i_flush_thread == w_sel);
        end
        S_REQ: begin
          if (w_flush_hit) r_cancel <= 1'b1;
`ifdef L2_REQ_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (w_flush_hit) r_cancel <= 1'b1;
`ifdef L2_REQ_TIMEOUT_EN
          // A watchdog expiry is acked like a cancelled request so the owner is released.
          if (!i_l2_rdy) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout) begin
              r_timeout_err <= 1'b1;
              r_cancel      <= 1'b1;
            end
          end
`endif
        end
        S_DONE: begin
          r_ptr    <= r_tid;
          r_cancel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed self-checking bench for l2_req_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_l2_req_arbiter;
  localparam int THREADS = 4;
  localparam int TID_W   = 2;
  localparam int ADDR_W  = 28;
  localparam int TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [THREADS-1:0]        req_valid;
  logic [THREADS-1:0]        req_dirty;
  logic [THREADS*ADDR_W-1:0] req_addr;
  logic                      flush;
  logic [TID_W-1:0]          flush_thread;
  logic                      l2_busy;
  logic                      l2_rdy;
  logic                      drq;
  logic [ADDR_W-1:0]         l2_addr;
  logic                      access_l2_clean;
  logic                      access_l2_dirty;
  logic [TID_W-1:0]          l2_thread;
  logic                      thread_rdy;
  logic [TID_W-1:0]          rdy_thread;
  logic [THREADS-1:0]        grant_ack;
  logic                      busy;
  logic                      timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  l2_req_arbiter #(.THREADS(THREADS), .TID_W(TID_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_dirty(req_dirty),
    .i_req_addr(req_addr), .i_flush(flush), .i_flush_thread(flush_thread),
    .i_l2_busy(l2_busy), .i_l2_rdy(l2_rdy), .o_drq(drq), .o_l2_addr(l2_addr),
    .o_access_l2_clean(access_l2_clean), .o_access_l2_dirty(access_l2_dirty),
    .o_l2_thread(l2_thread), .o_thread_rdy(thread_rdy), .o_rdy_thread(rdy_thread),
    .o_grant_ack(grant_ack), .o_busy(busy), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_dirty = '0; req_addr = '0;
    flush = 1'b0; flush_thread = '0; l2_busy = 1'b0; l2_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_dirty = '0; req_addr = '0;
    flush = 1'b0; flush_thread = '0; l2_busy = 1'b0; l2_rdy = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({drq, l2_addr, access_l2_clean, access_l2_dirty, l2_thread, thread_rdy, rdy_thread,
         grant_ack, busy, timeout_err} !== 42'd0)
      $display("FAIL reset_outputs got=%h exp=0", {drq, l2_addr, access_l2_clean, access_l2_dirty,
               l2_thread, thread_rdy, rdy_thread, grant_ack, busy, timeout_err});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_addr[0 +: ADDR_W] = 28'h0000123;
    @(negedge clk);
    n_chk++;
    if ({drq, l2_addr, access_l2_clean, access_l2_dirty, l2_thread, busy} !== {1'b1, 28'h0000123, 1'b1, 1'b0, 2'd0, 1'b1})
      $display("FAIL single_req got=%h exp=%h", {drq, l2_addr, access_l2_clean, access_l2_dirty, l2_thread, busy},
               {1'b1, 28'h0000123, 1'b1, 1'b0, 2'd0, 1'b1});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({drq, l2_addr, access_l2_clean, busy} !== {1'b0, 28'h0000123, 1'b1, 1'b1})
      $display("FAIL single_wait got=%h exp=%h", {drq, l2_addr, access_l2_clean, busy}, {1'b0, 28'h0000123, 1'b1, 1'b1});
    else n_pass++;
    @(negedge clk);
    l2_rdy = 1'b1;
    @(negedge clk);
    l2_rdy = 1'b0;
    n_chk++;
    if ({thread_rdy, rdy_thread, grant_ack, busy} !== {1'b1, 2'd0, 4'b0001, 1'b1})
      $display("FAIL single_done got=%h exp=%h", {thread_rdy, rdy_thread, grant_ack, busy}, {1'b1, 2'd0, 4'b0001, 1'b1});
    else n_pass++;
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if ({busy, grant_ack, thread_rdy, access_l2_clean, drq} !== 8'd0)
      $display("FAIL single_idle got=%h exp=0", {busy, grant_ack, thread_rdy, access_l2_clean, drq});
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic             seen;
    logic [3:0]       exp_ack;
    logic [TID_W-1:0] exp_tid;
    logic [ADDR_W-1:0] exp_addr;
    logic             exp_dirty;
    do_reset();
    for (int i = 0; i < THREADS; i++) req_addr[i*ADDR_W +: ADDR_W] = 28'h0000A00 + ADDR_W'(i);
    req_dirty = 4'b0100;
    req_valid = 4'b1111;
    for (int g = 0; g < THREADS; g++) begin
      exp_ack = 4'b0001 << g; exp_tid = TID_W'(g);
      exp_addr = 28'h0000A00 + ADDR_W'(g); exp_dirty = (g == 2);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (drq) seen = 1'b1;
      end
      n_chk++;
      if (seen !== 1'b1) $display("FAIL rr_drq_timeout got=%b exp=1 grant=%0d", seen, g);
      else n_pass++;
      n_chk++;
      if ({l2_thread, l2_addr, access_l2_dirty, access_l2_clean} !== {exp_tid, exp_addr, exp_dirty, !exp_dirty})
        $display("FAIL rr_grant got=%h exp=%h grant=%0d", {l2_thread, l2_addr, access_l2_dirty, access_l2_clean},
                 {exp_tid, exp_addr, exp_dirty, !exp_dirty}, g);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (drq !== 1'b0) $display("FAIL rr_drq_one_cycle got=%b exp=0 grant=%0d", drq, g);
      else n_pass++;
      l2_rdy = 1'b1;
      @(negedge clk);
      l2_rdy = 1'b0;
      n_chk++;
      if ({grant_ack, thread_rdy, rdy_thread} !== {exp_ack, 1'b1, exp_tid})
        $display("FAIL rr_done got=%h exp=%h grant=%0d", {grant_ack, thread_rdy, rdy_thread}, {exp_ack, 1'b1, exp_tid}, g);
      else n_pass++;
      req_valid[g] = 1'b0;
    end
    req_dirty = '0;
  endtask

  task automatic test_l2_busy();
    do_reset();
    l2_busy = 1'b1;
    req_valid = 4'b0100; req_addr[2*ADDR_W +: ADDR_W] = 28'h2222222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({drq, busy} !== 2'b00) $display("FAIL busy_hold got=%b exp=00 cycle=%0d", {drq, busy}, c);
      else n_pass++;
    end
    l2_busy = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({drq, l2_thread, l2_addr} !== {1'b1, 2'd2, 28'h2222222})
      $display("FAIL busy_release got=%h exp=%h", {drq, l2_thread, l2_addr}, {1'b1, 2'd2, 28'h2222222});
    else n_pass++;
    @(negedge clk);
    l2_rdy = 1'b1;
    @(negedge clk);
    l2_rdy = 1'b0;
    n_chk++;
    if ({grant_ack, thread_rdy, rdy_thread} !== {4'b0100, 1'b1, 2'd2})
      $display("FAIL busy_done got=%h exp=%h", {grant_ack, thread_rdy, rdy_thread}, {4'b0100, 1'b1, 2'd2});
    else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_flush();
    logic seen;
    do_reset();
    req_valid = 4'b0010; req_dirty = 4'b0010; req_addr[1*ADDR_W +: ADDR_W] = 28'hABCDEF1;
    @(negedge clk);
    n_chk++;
    if ({drq, l2_thread, access_l2_dirty, access_l2_clean} !== {1'b1, 2'd1, 1'b1, 1'b0})
      $display("FAIL flush_req got=%h exp=%h", {drq, l2_thread, access_l2_dirty, access_l2_clean}, {1'b1, 2'd1, 1'b1, 1'b0});
    else n_pass++;
    @(negedge clk);
    flush = 1'b1; flush_thread = 2'd1;
    @(negedge clk);
    flush = 1'b0; l2_rdy = 1'b1;
    @(negedge clk);
    l2_rdy = 1'b0;
    n_chk++;
    if ({grant_ack, thread_rdy} !== {4'b0010, 1'b0})
      $display("FAIL flush_cancel got=%h exp=%h", {grant_ack, thread_rdy}, {4'b0010, 1'b0});
    else n_pass++;
    req_valid = 4'b1000; req_dirty = '0; req_addr[3*ADDR_W +: ADDR_W] = 28'h3333333;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (drq) seen = 1'b1;
    end
    n_chk++;
    if ({seen, l2_thread, l2_addr} !== {1'b1, 2'd3, 28'h3333333})
      $display("FAIL flush_next_grant got=%h exp=%h", {seen, l2_thread, l2_addr}, {1'b1, 2'd3, 28'h3333333});
    else n_pass++;
    @(negedge clk);
    flush = 1'b1; flush_thread = 2'd0;
    @(negedge clk);
    flush = 1'b0; l2_rdy = 1'b1;
    @(negedge clk);
    l2_rdy = 1'b0;
    n_chk++;
    if ({thread_rdy, rdy_thread, grant_ack} !== {1'b1, 2'd3, 4'b1000})
      $display("FAIL flush_other_thread got=%h exp=%h", {thread_rdy, rdy_thread, grant_ack}, {1'b1, 2'd3, 4'b1000});
    else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    req_valid = 4'b0001; req_addr[0 +: ADDR_W] = 28'h0000456;
    @(negedge clk);
    n_chk++;
    if (drq !== 1'b1) $display("FAIL rstwait_drq got=%b exp=1", drq);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    @(negedge clk);
    n_chk++;
    if ({drq, l2_addr, access_l2_clean, access_l2_dirty, l2_thread, thread_rdy, rdy_thread,
         grant_ack, busy, timeout_err} !== 42'd0)
      $display("FAIL rstwait_outputs got=%h exp=0", {drq, l2_addr, access_l2_clean, access_l2_dirty,
               l2_thread, thread_rdy, rdy_thread, grant_ack, busy, timeout_err});
    else n_pass++;
    reset = 1'b0; l2_rdy = 1'b1;
    @(negedge clk);
    l2_rdy = 1'b0;
    n_chk++;
    if ({thread_rdy, grant_ack, busy, drq} !== 7'd0)
      $display("FAIL rstwait_stray_rdy got=%h exp=0", {thread_rdy, grant_ack, busy, drq});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({thread_rdy, grant_ack, busy, drq} !== 7'd0)
      $display("FAIL rstwait_after got=%h exp=0", {thread_rdy, grant_ack, busy, drq});
    else n_pass++;
  endtask

`ifdef L2_REQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    n_chk++;
    if (drq !== 1'b1) $display("FAIL to_drq got=%b exp=1", drq);
    else n_pass++;
    repeat (TIMEOUT) @(negedge clk);
    n_chk++;
    if ({timeout_err, busy, grant_ack} !== {1'b0, 1'b1, 4'b0000})
      $display("FAIL to_last_wait got=%h exp=%h", {timeout_err, busy, grant_ack}, {1'b0, 1'b1, 4'b0000});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({timeout_err, grant_ack, thread_rdy} !== {1'b1, 4'b0001, 1'b0})
      $display("FAIL to_done got=%h exp=%h", {timeout_err, grant_ack, thread_rdy}, {1'b1, 4'b0001, 1'b0});
    else n_pass++;
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if ({busy, timeout_err} !== 2'b01) $display("FAIL to_sticky got=%b exp=01", {busy, timeout_err});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_l2_busy();
    test_flush();
    test_reset_in_wait();
`ifdef L2_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Shares the single L1-D to L2 refill/writeback port between the hardware threads of the data cache.
- Each thread's miss logic raises a level request carrying its line address and victim-dirty flag.
- The arbiter picks one request round-robin, drives the L2 request signals tagged with the thread ID, waits for L2 completion, then pulses ready back to the owning thread.
- Sits between the per-thread dcache miss handlers and the L2 cache interface (drq, l2_busy, l2_rdy).

Parameters:
- THREADS, 4, number of requesting hardware threads.
- TID_W, 2, thread ID width; must equal clog2(THREADS).
- ADDR_W, 28, line address width (word address bits 31:4 equivalent).
- TIMEOUT, 255, watchdog limit in cycles for WAIT; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  THREADS  per-thread miss request; level, held until that thread's grant_ack.
- req_dirty  in  THREADS  per-thread victim-dirty flag; sampled with the request.
- req_addr  in  THREADS*ADDR_W  flattened line addresses; thread i occupies bits [i*ADDR_W +: ADDR_W].
- flush  in  1  pipeline flush of the thread named by flush_thread.
- flush_thread  in  TID_W  thread being flushed.
- l2_busy  in  1  L2 cannot accept a new request this cycle.
- l2_rdy  in  1  single-cycle pulse: L2 transaction complete.
- drq  out  1  L2 request strobe.
- l2_addr  out  ADDR_W  latched address of the granted request.
- access_l2_clean  out  1  granted request is a clean refill.
- access_l2_dirty  out  1  granted request needs writeback plus refill.
- l2_thread  out  TID_W  ID of the granted thread.
- thread_rdy  out  1  pulse: granted thread's refill is complete.
- rdy_thread  out  TID_W  thread ID qualifying thread_rdy.
- grant_ack  out  THREADS  one-hot pulse; requester must drop req_valid in the following cycle.
- busy  out  1  arbiter not in IDLE.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0.
  - State = IDLE; round-robin pointer ptr = THREADS-1, so thread 0 has first priority.
  - The cancel flag is cleared.
  - A reset asserted in any state abandons the transaction; a late l2_rdy arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If |req_valid and l2_busy==0, select the first set bit searching ptr+1, ptr+2, ... modulo THREADS.
  - Latch its tid, address and dirty flag; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - drq=1 for exactly one cycle.
  - l2_addr and l2_thread show the latched values.
  - access_l2_dirty = latched dirty; access_l2_clean = its inverse.
  - Go to WAIT.
- WAIT:
  - drq=0.
  - l2_addr, l2_thread and access_l2_* stay stable until DONE exits.
  - On l2_rdy go to DONE.
- DONE (one cycle):
  - grant_ack[tid]=1.
  - thread_rdy=1 with rdy_thread=tid, unless the cancel flag is set.
  - ptr <= tid; go to IDLE.
  - The access_l2_* signals clear on entry to IDLE.
- Latency:
  - req_valid seen at cycle 0 in IDLE with L2 free gives drq at cycle 1.
  - l2_rdy at cycle k gives thread_rdy/grant_ack at cycle k+1.
  - The next grant is possible at cycle k+2 (IDLE evaluates at k+2, drq at k+3).
- Flush:
  - If flush is asserted and flush_thread equals the latched tid while in REQ/WAIT, set the cancel flag.
  - The L2 transaction still runs to l2_rdy; DONE suppresses thread_rdy but still pulses grant_ack.
  - A flush of a non-granted thread has no effect on the arbiter; that requester drops its own req_valid.
  - A flush coinciding with the IDLE grant cycle is applied to the new grant.
- Simultaneous events:
  - A request rising while the arbiter is busy waits.
  - A requester whose grant_ack pulses is excluded from selection in that cycle; the next IDLE sees its lowered req_valid.
  - l2_rdy outside WAIT is ignored.
- Wrap-around: the search wraps from THREADS-1 to 0; a single persistent requester is re-granted each round.
- Fairness: with all threads requesting, the grant order is strictly 0,1,2,3,0...

Optional Feature:
- Macro L2_REQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without l2_rdy, set timeout_err (sticky until reset) and go to DONE.
  - In that DONE, grant_ack pulses and thread_rdy is suppressed.
- Undefined: no counter; timeout_err is tied to 0; WAIT is unbounded.

Test Plan:
- Reset, then req_valid=4'b0001, addr0=28'h0000123, dirty0=0, l2_busy=0, l2_rdy 3 cycles after drq.
  - Required: drq one cycle with l2_addr=28'h0000123 and access_l2_clean=1.
  - Required: thread_rdy with rdy_thread=0 and grant_ack=4'b0001 the cycle after l2_rdy.
- req_valid=4'b1111 held, each dropped after its ack, l2_rdy 2 cycles after each drq.
  - Required: grants in order 0,1,2,3, one at a time; the dirty flag on thread 2 gives access_l2_dirty=1 only for its grant.
- l2_busy=1 for 5 cycles with req_valid=4'b0100.
  - Required: no drq during the busy window; drq the cycle after the first cycle l2_busy=0.
- Thread 1 granted, flush=1 with flush_thread=1 during WAIT.
  - Required: l2_rdy gives grant_ack=4'b0010 and thread_rdy stays 0; the next request is granted normally.
- reset pulsed during WAIT, then a stray l2_rdy.
  - Required: all outputs 0, busy=0, and no thread_rdy.
- With L2_REQ_TIMEOUT_EN and TIMEOUT=8, no l2_rdy.
  - Required: timeout_err=1 after 8 WAIT cycles, grant_ack pulses, and busy returns to 0.
